// File: rtl/mp_add_pkg.sv
// rtl/mp_add_pkg.sv - shared constants and types for the multi-precision add sequencer
package mp_add_pkg;

    localparam int SLICE_W   = 64;
    localparam int MAX_LIMBS = 8;
    localparam int IDX_W     = $clog2(MAX_LIMBS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/add64_slice.sv
// rtl/add64_slice.sv - combinational 64-bit carry-lookahead adder slice
module add64_slice
    import mp_add_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               cin,
    output logic [SLICE_W-1:0] sum,
    output logic               cout
);

    localparam int NG = SLICE_W / 4;

    logic [SLICE_W-1:0] g;
    logic [SLICE_W-1:0] p;
    logic [SLICE_W-1:0] c;
    logic [NG:0]        c_grp;
    logic [NG-1:0]      gg;
    logic [NG-1:0]      gp;

    // 4-bit lookahead groups; each group's carry-out feeds the next group
    always_comb begin
        g     = a & b;
        p     = a ^ b;
        c     = '0;
        c_grp = '0;
        gg    = '0;
        gp    = '0;
        c_grp[0] = cin;
        for (int k = 0; k < NG; k++) begin
            c[4*k]   = c_grp[k];
            c[4*k+1] = g[4*k] | (p[4*k] & c_grp[k]);
            c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k])
                     | (p[4*k+1] & p[4*k] & c_grp[k]);
            c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1])
                     | (p[4*k+2] & p[4*k+1] & g[4*k])
                     | (p[4*k+2] & p[4*k+1] & p[4*k] & c_grp[k]);
            gg[k] = g[4*k+3] | (p[4*k+3] & g[4*k+2])
                  | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                  | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
            gp[k] = &p[4*k +: 4];
            c_grp[k+1] = gg[k] | (gp[k] & c_grp[k]);
        end
    end

    assign sum  = p ^ c;
    assign cout = c_grp[NG];

endmodule

// File: rtl/mp_add_sequencer.sv
// rtl/mp_add_sequencer.sv - multi-limb add/subtract using one shared 64-bit slice
module mp_add_sequencer #(
    parameter int LIMBS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  op_sub,
    input  logic [64*LIMBS-1:0]   a,
    input  logic [64*LIMBS-1:0]   b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [64*LIMBS-1:0]   sum,
    output logic                  cout,
    output logic                  ovf
);

    import mp_add_pkg::*;

    localparam int                W        = SLICE_W * LIMBS;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(LIMBS - 1);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               carry_q, carry_d;
    logic               op_q, op_d;
    logic [W-1:0]       a_q, a_d;
    logic [W-1:0]       b_q, b_d;
    logic [W-1:0]       sum_q, sum_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;

    logic [SLICE_W-1:0] slice_a;
    logic [SLICE_W-1:0] b_raw;
    logic [SLICE_W-1:0] slice_b;
    logic [SLICE_W-1:0] slice_sum;
    logic               slice_cout;

    // Pick the current limb of each captured operand; subtract inverts b and relies on carry-in = 1
    always_comb begin
        slice_a = '0;
        b_raw   = '0;
        for (int i = 0; i < LIMBS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                slice_a = a_q[i*SLICE_W +: SLICE_W];
                b_raw   = b_q[i*SLICE_W +: SLICE_W];
            end
        end
        slice_b = b_raw ^ {SLICE_W{op_q}};
    end

    add64_slice u_slice (
        .a    (slice_a),
        .b    (slice_b),
        .cin  (carry_q),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    // Next-state and datapath updates; handshake outputs decode directly from state
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        carry_d   = carry_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        sum_d     = sum_q;
        cout_d    = cout_q;
        ovf_d     = ovf_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;

        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    op_d    = op_sub;
                    carry_d = op_sub;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                for (int i = 0; i < LIMBS; i++) begin
                    if (idx_q == IDX_W'(i)) begin
                        sum_d[i*SLICE_W +: SLICE_W] = slice_sum;
                    end
                end
                carry_d = slice_cout;
                if (idx_q == LAST_IDX) begin
                    // Index parks on the last limb so it never wraps into a second pass
                    state_d = DONE;
                    cout_d  = slice_cout;
                    ovf_d   = (slice_a[SLICE_W-1] == slice_b[SLICE_W-1])
                            && (slice_sum[SLICE_W-1] != slice_a[SLICE_W-1]);
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any operation in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            op_q    <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_mp_add_sequencer.sv
// tb/tb_mp_add_sequencer.sv - directed self-checking bench for mp_add_sequencer
module tb_mp_add_sequencer;

    localparam int LIMBS = 4;
    localparam int W     = 64 * LIMBS;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic         op_sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    int tests = 0;
    int fails = 0;
    int lat;

    mp_add_sequencer #(.LIMBS(LIMBS)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_sub    (op_sub),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Handshake one operation, scramble inputs afterwards, count edges until out_valid
    task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sub,
                          output int latency);
        in_valid = 1'b1;
        a        = av;
        b        = bv;
        op_sub   = sub;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a        = ~av;
        b        = ~bv;
        op_sub   = ~sub;
        latency  = 99;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                latency = c;
                break;
            end
        end
    endtask

    task automatic do_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic sub, input logic [W-1:0] esum, input logic ecout,
                         input logic eovf);
        int l;
        run_op(av, bv, sub, l);
        chk({tag, "_lat"}, W'(l), W'(LIMBS));
        chk({tag, "_sum"}, sum, esum);
        chk({tag, "_cout"}, W'(cout), W'(ecout));
        chk({tag, "_ovf"}, W'(ovf), W'(eovf));
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({tag, "_drop"}, W'(out_valid), W'(0));
        chk({tag, "_idle"}, W'(in_ready), W'(1));
    endtask

    initial begin
        logic [W-1:0] ones;
        logic [W-1:0] top;
        ones      = '1;
        top       = '0;
        top[W-1]  = 1'b1;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        op_sub    = 1'b0;
        a         = '0;
        b         = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_out_valid", W'(out_valid), W'(0));
        chk("rst_in_ready", W'(in_ready), W'(1));
        chk("rst_sum", sum, '0);
        chk("rst_cout", W'(cout), W'(0));
        chk("rst_ovf", W'(ovf), W'(0));

        do_op("add_small", W'(1), W'(2), 1'b0, W'(3), 1'b0, 1'b0);
        do_op("limb_carry", W'(64'hFFFF_FFFF_FFFF_FFFF), W'(1), 1'b0,
              {W'(1)} << 64, 1'b0, 1'b0);
        do_op("full_wrap", ones, W'(1), 1'b0, '0, 1'b1, 1'b0);
        do_op("sgn_ovf", ~top, W'(1), 1'b0, top, 1'b0, 1'b1);
        do_op("sub_borrow", W'(5), W'(7), 1'b1, ~W'(1), 1'b0, 1'b0);
        do_op("sub_pos", W'(7), W'(5), 1'b1, W'(2), 1'b1, 1'b0);
        do_op("sub_sovf", top, W'(1), 1'b1, ~top, 1'b1, 1'b1);

        // Backpressure: hold result while a stray in_valid is presented
        run_op(W'(10), W'(20), 1'b0, lat);
        chk("bp_lat", W'(lat), W'(LIMBS));
        for (int c = 0; c < 10; c++) begin
            if (c == 3) begin
                in_valid = 1'b1;
                a        = W'(99);
                b        = W'(99);
                op_sub   = 1'b0;
            end
            if (c == 6) in_valid = 1'b0;
            @(posedge clk);
            #1;
            chk("bp_sum", sum, W'(30));
            chk("bp_cout", W'(cout), W'(0));
            chk("bp_ovf", W'(ovf), W'(0));
            chk("bp_valid", W'(out_valid), W'(1));
            chk("bp_in_ready", W'(in_ready), W'(0));
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("bp_release_valid", W'(out_valid), W'(0));
        chk("bp_release_ready", W'(in_ready), W'(1));
        chk("bp_sum_kept", sum, W'(30));
        repeat (6) @(posedge clk);
        #1;
        chk("bp_no_capture", W'(out_valid), W'(0));
        chk("bp_idle_ready", W'(in_ready), W'(1));

        // Reset during the second RUN cycle discards the operation
        in_valid = 1'b1;
        a        = ones;
        b        = W'(1);
        op_sub   = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("mid_rst_valid", W'(out_valid), W'(0));
        chk("mid_rst_sum", sum, '0);
        chk("mid_rst_ready", W'(in_ready), W'(1));
        repeat (6) @(posedge clk);
        #1;
        chk("mid_rst_no_result", W'(out_valid), W'(0));
        do_op("after_rst", W'(3), W'(4), 1'b0, W'(7), 1'b0, 1'b0);

        // Reset wins over a simultaneous in_valid
        rst      = 1'b1;
        in_valid = 1'b1;
        a        = W'(8);
        b        = W'(9);
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        chk("rst_win_ready", W'(in_ready), W'(1));
        repeat (6) @(posedge clk);
        #1;
        chk("rst_win_no_result", W'(out_valid), W'(0));
        chk("rst_win_sum", sum, '0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mp_add_sequencer.md
MP_ADD_SEQUENCER -- requirements
Module: mp_add_sequencer

Interface
REQ-001 The block SHALL have parameter LIMBS, default 4, giving the number of 64-bit limbs per operand; legal range 2..8.
REQ-002 The block SHALL have one clock and a synchronous, active-high reset.
REQ-003 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 Port in_valid, input, 1 bit: an operand pair and opcode are presented.
REQ-006 Port in_ready, output, 1 bit: the block can accept an operation.
REQ-007 Port op_sub, input, 1 bit: 0 selects a+b; 1 selects a-b.
REQ-008 Port a, input, 64*LIMBS bits: first operand.
REQ-009 Port b, input, 64*LIMBS bits: second operand.
REQ-010 Port out_valid, output, 1 bit: the result is valid.
REQ-011 Port out_ready, input, 1 bit: the consumer accepts the result.
REQ-012 Port sum, output, 64*LIMBS bits: the result.
REQ-013 Port cout, output, 1 bit: unsigned carry out; for subtract, 1 means no borrow (a >= b).
REQ-014 Port ovf, output, 1 bit: two's-complement signed overflow.

Function
REQ-015 The block SHALL time-share one combinational 64-bit adder slice over LIMBS cycles, least-significant limb first.
REQ-016 The FSM SHALL have the states IDLE, RUN and DONE.
REQ-017 In IDLE, in_ready SHALL be 1; in every other state it SHALL be 0.
REQ-018 When in_valid and in_ready are both 1 at a clock edge, the block SHALL:
- capture a, b and op_sub;
- load the carry register with op_sub;
- set the limb index to 0;
- enter RUN.
REQ-019 Each RUN cycle SHALL compute limb[idx] = a_limb + (b_limb XOR {64{op_sub}}) + carry, write it to sum limb idx, load carry with the slice carry-out, and increment idx.
REQ-020 At the edge that processes idx = LIMBS-1, the FSM SHALL enter DONE and SHALL set cout to the final carry and ovf to (a_msb == b'_msb) AND (sum_msb != a_msb), where b' is the possibly inverted b.
REQ-021 Latency: out_valid SHALL rise exactly LIMBS cycles after the input handshake edge.
REQ-022 In DONE, out_valid SHALL be 1 and sum, cout and ovf SHALL be held stable until out_ready is 1.
REQ-023 The output handshake (out_valid and out_ready both 1) SHALL return the FSM to IDLE; out_valid SHALL drop on the next cycle, and there is no same-cycle re-accept.
REQ-024 While not in IDLE, in_valid SHALL be ignored, with no capture and no error.
REQ-025 Operand inputs SHALL be sampled only at the handshake edge; later changes SHALL have no effect.
REQ-026 The limb index SHALL never exceed LIMBS-1; there is no wrap-around into a second pass.
REQ-027 sum SHALL keep its last result in IDLE until the next operation overwrites it limb by limb.

Reset
REQ-028 When rst=1 at a clock edge, the block SHALL, regardless of state:
- set the state to IDLE, out_valid=0, sum=0, cout=0, ovf=0, carry=0, idx=0;
- set in_ready=1 from the following cycle.
REQ-029 Reset asserted during RUN or DONE SHALL discard the operation in flight; no partial result SHALL become valid.
REQ-030 When rst and in_valid are both 1 at the same edge, reset SHALL win and nothing SHALL be captured.

Structure
REQ-031 Shared package mp_add_pkg SHALL hold:
- the SLICE_W=64 constant;
- the state enum (IDLE, RUN, DONE);
- the limb-index width derived from the maximum LIMBS.
REQ-032 Sub-module add64_slice SHALL be a purely combinational 64-bit carry-lookahead adder with ports a, b, cin, sum and cout, instantiated exactly once.
REQ-033 All registers SHALL live in mp_add_sequencer; add64_slice SHALL contain no state.

Verification
REQ-034 Add, small values (LIMBS=4): a=1, b=2, op_sub=0 -> sum=3, cout=0, ovf=0, out_valid exactly 4 cycles after accept.
REQ-035 Cross-limb carry: a=0xFFFF_FFFF_FFFF_FFFF, b=1 -> sum=2^64 (limb1=1, limb0=0), cout=0.
REQ-036 Full wrap: a=2^256-1, b=1 -> sum=0, cout=1, ovf=0. Signed overflow: a=2^255-1, b=1 -> sum=2^255, ovf=1.
REQ-037 Subtract: a=5, b=7, op_sub=1 -> sum=2^256-2, cout=0, ovf=0. With a=7, b=5 -> sum=2, cout=1.
REQ-038 Backpressure: out_ready held 0 for 10 cycles, new in_valid pulsed -> sum/cout/ovf stable, in_ready=0, no capture. Then out_ready=1 -> IDLE next cycle.
REQ-039 Reset mid-operation: rst=1 during the 2nd RUN cycle -> next cycle state IDLE, out_valid=0, sum=0, in_ready=1. A subsequent 3+4 gives sum=7.
